// File: rtl/spi_target_apb.sv
// SPI mode-0 target with an APB register face.
// MOSI frames are shifted MSB-first into an RX FIFO; MISO is driven from a TX FIFO.
// Sticky error flags record RX overrun, TX underrun and TX overflow; irq flags RX data.
module spi_target_apb #(
    parameter int FRAME_BITS  = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        cpu_reset_n,
    input  logic        spi_sck,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    input  logic [3:0]  apb_paddr,
    input  logic        apb_psel,
    input  logic        apb_penable,
    input  logic        apb_pwrite,
    input  logic [31:0] apb_pwdata,
    output logic [31:0] apb_prdata,
    output logic        apb_pready,
    output logic        irq
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int BW = $clog2(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    // ---------------- synchronisers and edge detect ----------------
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sck_prev;
    logic                   r_cs_prev;

    logic w_sck;
    logic w_cs;
    logic w_mosi;
    logic w_sck_rise;
    logic w_sck_fall;
    logic w_cs_fall;
    logic w_cs_rise;

    // Bring the SPI pins into the clk domain and keep the previous sample for edges
    always_ff @(posedge clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            r_sck_sync  <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sck_prev  <= 1'b0;
            r_cs_prev   <= 1'b1;
        end else begin
            r_sck_sync[0]  <= spi_sck;
            r_cs_sync[0]   <= spi_cs_n;
            r_mosi_sync[0] <= spi_mosi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sck_sync[i]  <= r_sck_sync[i-1];
                r_cs_sync[i]   <= r_cs_sync[i-1];
                r_mosi_sync[i] <= r_mosi_sync[i-1];
            end
            r_sck_prev <= w_sck;
            r_cs_prev  <= w_cs;
        end
    end

    assign w_sck      = r_sck_sync[SYNC_STAGES-1];
    assign w_cs       = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck & ~r_sck_prev;
    assign w_sck_fall = ~w_sck & r_sck_prev;
    assign w_cs_fall  = ~w_cs & r_cs_prev;
    assign w_cs_rise  = w_cs & ~r_cs_prev;

    // ---------------- state ----------------
    state_t                r_state;
    logic [FRAME_BITS-1:0] r_rx_shift;
    logic [FRAME_BITS-1:0] r_tx_shift;
    logic [BW-1:0]         r_bitcnt;
    logic                  r_reload;
    logic                  r_enable;
    logic                  r_rx_ovr;
    logic                  r_tx_udr;
    logic                  r_tx_ovf;
    logic                  r_acc_seen;
    logic                  r_rx_pop_arm;

    logic [FRAME_BITS-1:0] r_rx_mem [FIFO_DEPTH];
    logic [FRAME_BITS-1:0] r_tx_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_rx_wp, r_rx_rp, r_tx_wp, r_tx_rp;
    logic [CW-1:0]         r_rx_cnt, r_tx_cnt;

    // ---------------- APB decode ----------------
    logic [1:0]  w_reg;
    logic        w_acc;
    logic        w_setup_rd;
    logic        w_ctrl_wr;
    logic        w_tx_push_req;
    logic        w_rx_pop;
    logic [31:0] w_rdata;
    logic [7:0]  w_status;

    assign w_reg         = apb_paddr[3:2];
    assign w_acc         = apb_psel & apb_penable & ~r_acc_seen;
    assign w_setup_rd    = apb_psel & ~apb_penable & ~apb_pwrite;
    assign w_ctrl_wr     = w_acc & apb_pwrite & (w_reg == 2'd2);
    assign w_tx_push_req = w_acc & apb_pwrite & (w_reg == 2'd0);
    // The pop was armed at setup only if the data returned was a real RX entry
    assign w_rx_pop      = w_acc & ~apb_pwrite & (w_reg == 2'd0) & r_rx_pop_arm;

    // ---------------- FIFO status and handshakes ----------------
    logic                  w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
    logic [FRAME_BITS-1:0] w_rx_head, w_tx_head, w_load_word;
    logic                  w_abort, w_load_now;
    logic                  w_tx_pop, w_tx_push, w_tx_ovf_set;
    logic                  w_rx_push_req, w_rx_push, w_rx_ovr_set;
    logic [FRAME_BITS:0]   w_rx_cat;
    logic [FRAME_BITS-1:0] w_rx_next;
    logic [FRAME_BITS-1:0] w_tx_next;

    assign w_rx_empty  = (r_rx_cnt == CW'(0));
    assign w_rx_full   = (r_rx_cnt == CW'(FIFO_DEPTH));
    assign w_tx_empty  = (r_tx_cnt == CW'(0));
    assign w_tx_full   = (r_tx_cnt == CW'(FIFO_DEPTH));
    assign w_rx_head   = r_rx_mem[r_rx_rp];
    assign w_tx_head   = r_tx_mem[r_tx_rp];
    // An empty TX FIFO sends all-ones rather than stale data
    assign w_load_word = w_tx_empty ? {FRAME_BITS{1'b1}} : w_tx_head;

    assign w_rx_cat  = {r_rx_shift, w_mosi};
    assign w_rx_next = w_rx_cat[FRAME_BITS-1:0];
    assign w_tx_next = r_tx_shift << 1;

    // Losing CS or enable terminates the frame wherever it stands
    assign w_abort    = w_cs_rise | ~r_enable;
    assign w_load_now = ~w_abort & ((r_state == ST_LOAD) |
                                    ((r_state == ST_SHIFT) & w_sck_fall & r_reload));
    assign w_rx_push_req = ~w_abort & (r_state == ST_SHIFT) & w_sck_rise &
                           (r_bitcnt == BW'(FRAME_BITS - 1));

    assign w_tx_pop     = w_load_now & ~w_tx_empty;
    assign w_tx_push    = w_tx_push_req & (~w_tx_full | w_tx_pop);
    assign w_tx_ovf_set = w_tx_push_req & w_tx_full & ~w_tx_pop;
    assign w_rx_push    = w_rx_push_req & (~w_rx_full | w_rx_pop);
    assign w_rx_ovr_set = w_rx_push_req & w_rx_full & ~w_rx_pop;

    assign w_status = {~w_cs, r_tx_ovf, r_tx_udr, r_rx_ovr,
                       w_tx_full, w_tx_empty, w_rx_full, w_rx_empty};

    // Read data selected by the register index
    always_comb begin
        w_rdata = 32'd0;
        case (w_reg)
            2'd0:    w_rdata = w_rx_empty ? 32'd0 : 32'(w_rx_head);
            2'd1:    w_rdata = 32'(w_status);
            2'd2:    w_rdata = {31'd0, r_enable};
            default: w_rdata = 32'd0;
        endcase
    end

    // RX FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_rx_mem[i] <= '0;
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_rx_push) begin
                r_rx_mem[r_rx_wp] <= w_rx_next;
                r_rx_wp           <= r_rx_wp + AW'(1);
            end
            if (w_rx_pop) begin
                r_rx_rp <= r_rx_rp + AW'(1);
            end
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + CW'(1);
                2'b01:   r_rx_cnt <= r_rx_cnt - CW'(1);
                default: r_rx_cnt <= r_rx_cnt;
            endcase
        end
    end

    // TX FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_tx_mem[i] <= '0;
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= '0;
        end else begin
            if (w_tx_push) begin
                r_tx_mem[r_tx_wp] <= apb_pwdata[FRAME_BITS-1:0];
                r_tx_wp           <= r_tx_wp + AW'(1);
            end
            if (w_tx_pop) begin
                r_tx_rp <= r_tx_rp + AW'(1);
            end
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_cnt <= r_tx_cnt + CW'(1);
                2'b01:   r_tx_cnt <= r_tx_cnt - CW'(1);
                default: r_tx_cnt <= r_tx_cnt;
            endcase
        end
    end

    // SPI frame FSM: load, shift on sck edges, reload between frames, abort on CS rise
    always_ff @(posedge clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            r_state     <= ST_IDLE;
            r_rx_shift  <= '0;
            r_tx_shift  <= '0;
            r_bitcnt    <= '0;
            r_reload    <= 1'b0;
            spi_miso    <= 1'b1;
            spi_miso_oe <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    spi_miso_oe <= 1'b0;
                    spi_miso    <= 1'b1;
                    r_bitcnt    <= '0;
                    r_reload    <= 1'b0;
                    if (w_cs_fall && r_enable) begin
                        r_state <= ST_LOAD;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    r_reload <= 1'b0;
                    r_bitcnt <= '0;
                    if (w_abort) begin
                        r_state     <= ST_IDLE;
                        spi_miso_oe <= 1'b0;
                        spi_miso    <= 1'b1;
                    end else begin
                        r_tx_shift  <= w_load_word;
                        spi_miso    <= w_load_word[FRAME_BITS-1];
                        spi_miso_oe <= 1'b1;
                        r_state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_abort) begin
                        r_state     <= ST_IDLE;
                        r_bitcnt    <= '0;
                        r_reload    <= 1'b0;
                        spi_miso_oe <= 1'b0;
                        spi_miso    <= 1'b1;
                    end else if (w_sck_rise) begin
                        r_rx_shift <= w_rx_next;
                        if (r_bitcnt == BW'(FRAME_BITS - 1)) begin
                            r_bitcnt <= '0;
                            r_reload <= 1'b1;
                        end else begin
                            r_bitcnt <= r_bitcnt + BW'(1);
                        end
                    end else if (w_sck_fall) begin
                        if (r_reload) begin
                            r_tx_shift <= w_load_word;
                            spi_miso   <= w_load_word[FRAME_BITS-1];
                            r_reload   <= 1'b0;
                        end else begin
                            r_tx_shift <= w_tx_next;
                            spi_miso   <= w_tx_next[FRAME_BITS-1];
                        end
                    end else begin
                        r_state <= ST_SHIFT;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    spi_miso_oe <= 1'b0;
                    spi_miso    <= 1'b1;
                end
            endcase
        end
    end

    // Control register and sticky flags; a set event beats a same-cycle clear
    always_ff @(posedge clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            r_enable <= 1'b0;
            r_rx_ovr <= 1'b0;
            r_tx_udr <= 1'b0;
            r_tx_ovf <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_enable <= apb_pwdata[0];
            end else begin
                r_enable <= r_enable;
            end
            r_rx_ovr <= w_rx_ovr_set | (r_rx_ovr & ~(w_ctrl_wr & apb_pwdata[4]));
            r_tx_udr <= (w_load_now & w_tx_empty) | (r_tx_udr & ~(w_ctrl_wr & apb_pwdata[5]));
            r_tx_ovf <= w_tx_ovf_set | (r_tx_ovf & ~(w_ctrl_wr & apb_pwdata[6]));
            irq      <= r_enable & ~w_rx_empty;
        end
    end

    // APB read data captured at setup so it is valid through the access phase
    always_ff @(posedge clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            apb_prdata   <= 32'd0;
            r_rx_pop_arm <= 1'b0;
            r_acc_seen   <= 1'b0;
        end else begin
            r_acc_seen <= apb_psel & apb_penable;
            if (w_setup_rd) begin
                apb_prdata   <= w_rdata;
                r_rx_pop_arm <= (w_reg == 2'd0) & ~w_rx_empty;
            end else if (apb_psel && apb_penable && !apb_pwrite) begin
                apb_prdata   <= apb_prdata;
                r_rx_pop_arm <= r_rx_pop_arm;
            end else begin
                apb_prdata   <= 32'd0;
                r_rx_pop_arm <= 1'b0;
            end
        end
    end

    assign apb_pready = 1'b1;

    logic w_unused_bits;
    assign w_unused_bits = ^{apb_paddr[1:0], apb_pwdata, w_rx_cat[FRAME_BITS]};

endmodule
